// File: rtl/rx_unit.sv
// UART receiver with 16x oversampling.
// Recovers one 8N1 / 8O1 / 8E1 frame, LSB first, from an asynchronous serial
// line and presents the byte on Data with start/parity/stop status on
// error_flag. Both outputs hold until the next completed frame or start error.
module rx_unit #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       data_tx,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [2:0] error_flag,
    output logic [7:0] Data
);

    // Clocks per oversample tick, rounded to nearest, for each supported baud.
    localparam int DIV_2400  = (CLK_HZ + (OVERSAMPLE * 2400)  / 2) / (OVERSAMPLE * 2400);
    localparam int DIV_4800  = (CLK_HZ + (OVERSAMPLE * 4800)  / 2) / (OVERSAMPLE * 4800);
    localparam int DIV_9600  = (CLK_HZ + (OVERSAMPLE * 9600)  / 2) / (OVERSAMPLE * 9600);
    localparam int DIV_19200 = (CLK_HZ + (OVERSAMPLE * 19200) / 2) / (OVERSAMPLE * 19200);
    localparam int DIV_W     = $clog2(DIV_2400);
    localparam int TICK_W    = $clog2(OVERSAMPLE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [1:0]        sync_q;
    logic              line_prev;
    logic              line;
    logic [2:0]        state;
    logic [1:0]        baud_q;
    logic [1:0]        par_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_max;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_q;
    logic              par_err;
    logic              tick;
    logic              sample;
    logic              start_edge;
    logic              par_en;

    assign line       = sync_q[1];
    assign start_edge = (state == S_IDLE) && line_prev && !line;
    assign tick       = (div_cnt == div_max);
    assign sample     = tick && (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1));
    assign par_en     = (par_q == 2'b01) || (par_q == 2'b10);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection;
    // reset to the idle-high line level so release of reset is not an edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], data_tx};
            line_prev <= sync_q[1];
        end
    end

    // Divider terminal count selected by the baud rate latched for this frame.
    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        div_max = DIV_W'(DIV_2400 - 1);
        case (baud_q)
            2'b01:   div_max = DIV_W'(DIV_4800 - 1);
            2'b10:   div_max = DIV_W'(DIV_9600 - 1);
            2'b11:   div_max = DIV_W'(DIV_19200 - 1);
            default: div_max = DIV_W'(DIV_2400 - 1);
        endcase
    end

    // Tick generator and oversample counter, both re-phased on the start edge
    // so tick OVERSAMPLE/2 of every bit lands on the bit centre.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (start_edge) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) tick_cnt <= '0;
                else                                     tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Frame FSM: samples each slot at its centre and updates the outputs once,
    // at the stop sample (or at a failed start sample).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            baud_q     <= 2'b00;
            par_q      <= 2'b00;
            bit_cnt    <= 3'd0;
            shift_q    <= 8'h00;
            par_err    <= 1'b0;
            Data       <= 8'h00;
            error_flag <= 3'b000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state   <= S_START;
                        baud_q  <= baud_rate;
                        par_q   <= parity_type;
                        bit_cnt <= 3'd0;
                        par_err <= 1'b0;
                    end
                end
                S_START: begin
                    if (sample) begin
                        if (line) begin
                            error_flag <= 3'b010;
                            state      <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        shift_q <= {line, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (sample) begin
                        // Odd parity expects an odd count of ones over data+parity.
                        par_err <= (par_q == 2'b01) ? ~(^shift_q ^ line) : (^shift_q ^ line);
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        Data       <= shift_q;
                        error_flag <= {~line, 1'b0, par_err};
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_unit.sv
// Directed testbench for rx_unit. Runs the receiver with a 5 MHz CLK_HZ so
// each frame stays short; bit periods below are 16 x round(5e6 / (16 x baud)).
module tb_rx_unit;

    localparam int CLK_HZ    = 5_000_000;
    localparam int BIT_2400  = 16 * 130;
    localparam int BIT_4800  = 16 * 65;
    localparam int BIT_9600  = 16 * 33;
    localparam int BIT_19200 = 16 * 16;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       data_tx;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic [2:0] error_flag;
    logic [7:0] Data;

    int n_checks = 0;
    int n_fail   = 0;

    rx_unit #(.CLK_HZ(CLK_HZ), .OVERSAMPLE(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data_tx     (data_tx),
        .parity_type (parity_type),
        .baud_rate   (baud_rate),
        .error_flag  (error_flag),
        .Data        (Data)
    );

    always #5 clock = ~clock;

    // Hold the line at one level for nclk clocks; returns on a falling edge.
    task automatic send_bit(input logic b, input int nclk);
        data_tx = b;
        repeat (nclk) @(negedge clock);
    endtask

    // Full frame; baud/parity inputs are moved to mid_* after the start bit
    // to show they are ignored until the next start edge.
    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par_bit,
                              input logic stop_bit, input int bclk,
                              input logic [1:0] mid_baud, input logic [1:0] mid_par);
        send_bit(1'b0, bclk);
        baud_rate   = mid_baud;
        parity_type = mid_par;
        for (int i = 0; i < 8; i++) send_bit(d[i], bclk);
        if (has_par) send_bit(par_bit, bclk);
        send_bit(stop_bit, bclk);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        data_tx     = 1'b1;
        parity_type = 2'b00;
        baud_rate   = 2'b00;
        repeat (3) @(negedge clock);
        n_checks++;
        if (Data !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h expected 00", Data);
        end
        n_checks++;
        if (error_flag !== 3'b000) begin
            n_fail++; $display("FAIL reset_flag: got %b expected 000", error_flag);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_odd_parity();
        baud_rate   = 2'b10;
        parity_type = 2'b01;
        send_bit(1'b1, BIT_9600);
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, BIT_9600, 2'b00, 2'b00);
        n_checks++;
        if (Data !== 8'h55) begin
            n_fail++; $display("FAIL odd_data: got %h expected 55", Data);
        end
        n_checks++;
        if (error_flag !== 3'b000) begin
            n_fail++; $display("FAIL odd_flag: got %b expected 000", error_flag);
        end
    endtask

    task automatic test_even_parity_error();
        baud_rate   = 2'b10;
        parity_type = 2'b10;
        send_bit(1'b1, BIT_9600);
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, BIT_9600, 2'b10, 2'b01);
        n_checks++;
        if (Data !== 8'h55) begin
            n_fail++; $display("FAIL even_data: got %h expected 55", Data);
        end
        n_checks++;
        if (error_flag !== 3'b001) begin
            n_fail++; $display("FAIL even_flag: got %b expected 001", error_flag);
        end
    endtask

    task automatic test_stop_error();
        baud_rate   = 2'b11;
        parity_type = 2'b00;
        send_bit(1'b1, BIT_19200);
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, BIT_19200, 2'b11, 2'b00);
        n_checks++;
        if (Data !== 8'hA3) begin
            n_fail++; $display("FAIL stop_data: got %h expected a3", Data);
        end
        n_checks++;
        if (error_flag !== 3'b100) begin
            n_fail++; $display("FAIL stop_flag: got %b expected 100", error_flag);
        end
        send_bit(1'b1, BIT_19200);
    endtask

    task automatic test_glitch();
        baud_rate   = 2'b00;
        parity_type = 2'b00;
        send_bit(1'b1, BIT_2400);
        send_bit(1'b0, BIT_2400 / 4);
        n_checks++;
        if (error_flag !== 3'b100) begin
            n_fail++; $display("FAIL glitch_early_flag: got %b expected 100", error_flag);
        end
        send_bit(1'b1, BIT_2400);
        n_checks++;
        if (error_flag !== 3'b010) begin
            n_fail++; $display("FAIL glitch_flag: got %b expected 010", error_flag);
        end
        n_checks++;
        if (Data !== 8'hA3) begin
            n_fail++; $display("FAIL glitch_data: got %h expected a3", Data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] partial;
        partial     = 8'h55;
        baud_rate   = 2'b11;
        parity_type = 2'b00;
        send_bit(1'b1, BIT_19200);
        send_bit(1'b0, BIT_19200);
        for (int i = 0; i < 4; i++) send_bit(partial[i], BIT_19200);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (Data !== 8'h00) begin
            n_fail++; $display("FAIL midreset_data: got %h expected 00", Data);
        end
        n_checks++;
        if (error_flag !== 3'b000) begin
            n_fail++; $display("FAIL midreset_flag: got %b expected 000", error_flag);
        end
        data_tx = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        send_bit(1'b1, BIT_19200);
        send_frame(8'hC4, 1'b0, 1'b0, 1'b1, BIT_19200, 2'b11, 2'b00);
        n_checks++;
        if (Data !== 8'hC4) begin
            n_fail++; $display("FAIL after_reset_data: got %h expected c4", Data);
        end
        n_checks++;
        if (error_flag !== 3'b000) begin
            n_fail++; $display("FAIL after_reset_flag: got %b expected 000", error_flag);
        end
    endtask

    task automatic test_back_to_back();
        baud_rate   = 2'b01;
        parity_type = 2'b10;
        send_bit(1'b1, BIT_4800);
        send_frame(8'h00, 1'b1, 1'b0, 1'b1, BIT_4800, 2'b01, 2'b10);
        n_checks++;
        if (Data !== 8'h00) begin
            n_fail++; $display("FAIL b2b_first_data: got %h expected 00", Data);
        end
        n_checks++;
        if (error_flag !== 3'b000) begin
            n_fail++; $display("FAIL b2b_first_flag: got %b expected 000", error_flag);
        end
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1, BIT_4800, 2'b01, 2'b10);
        n_checks++;
        if (Data !== 8'hFF) begin
            n_fail++; $display("FAIL b2b_second_data: got %h expected ff", Data);
        end
        n_checks++;
        if (error_flag !== 3'b000) begin
            n_fail++; $display("FAIL b2b_second_flag: got %b expected 000", error_flag);
        end
        send_bit(1'b1, BIT_4800);
    endtask

    initial begin
        test_reset();
        test_odd_parity();
        test_even_parity_error();
        test_stop_error();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
